// File: rtl/mlaccel_pkg.sv
// Shared types for the main-memory arbiter: FSM states, read-tag owner and tag layout.
package mlaccel_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    LAST_HOST = 2'd0,
    LAST_COMP = 2'd1,
    LOCKED    = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_COMP = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

endpackage

// File: rtl/mlaccel_memarb_tagpipe.sv
// Shift register of {valid, owner} read tags, MEM_LAT+1 stages deep, steering rvalid.
module mlaccel_memarb_tagpipe
  import mlaccel_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  logic i_owner,
  output logic o_host_rvalid,
  output logic o_comp_rvalid,
  output logic o_host_pending
);

  tag_t r_tag [MEM_LAT+1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i <= MEM_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: i_push, owner: owner_e'(i_owner)};
      for (int unsigned i = 1; i <= MEM_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign o_host_rvalid = r_tag[MEM_LAT].valid && (r_tag[MEM_LAT].owner == OWN_HOST);
  assign o_comp_rvalid = r_tag[MEM_LAT].valid && (r_tag[MEM_LAT].owner == OWN_COMP);

  // Host reads count as in flight from the accept edge until their rvalid cycle ends.
  always_comb begin
    o_host_pending = 1'b0;
    for (int unsigned i = 0; i <= MEM_LAT; i++) begin
      if (r_tag[i].valid && (r_tag[i].owner == OWN_HOST)) begin
        o_host_pending = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mlaccel_memarb.sv
// Host/compute arbiter for the single-port main memory with registered memory outputs.
// Optional lock-duration limit enabled by defining MEMARB_LOCK_LIMIT_EN.
module mlaccel_memarb
  import mlaccel_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MEM_LAT  = 1,
  parameter int MAX_LOCK = 64
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              comp_valid,
  output logic              comp_ready,
  input  logic              comp_we,
  input  logic [ADDR_W-1:0] comp_addr,
  input  logic [DATA_W-1:0] comp_wdata,
  output logic              comp_rvalid,
  output logic [DATA_W-1:0] comp_rdata,
  input  logic              comp_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic              w_host_ready;
  logic              w_comp_ready;
  logic              w_host_acc;
  logic              w_comp_acc;
  logic              w_lim_hit;
  logic              w_release;
  logic              w_host_pending;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

`ifdef MEMARB_LOCK_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W:0] LOCK_LIM = (CNT_W+1)'(MAX_LOCK);
  localparam logic [CNT_W:0] CNT_ONE  = (CNT_W+1)'(1);

  logic [CNT_W:0] r_lock_cnt;
  logic [CNT_W:0] w_cnt_inc;

  // The lock-entering beat is counted, so MAX_LOCK bounds the whole locked burst.
  assign w_cnt_inc = ((r_state == LOCKED) ? r_lock_cnt : '0) + CNT_ONE;
  assign w_lim_hit = (w_cnt_inc >= LOCK_LIM) && host_valid;
  assign w_release = (r_state == LOCKED) && (r_lock_cnt >= LOCK_LIM) && host_valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_lock_cnt <= '0;
    end else if (w_next != LOCKED) begin
      r_lock_cnt <= '0;
    end else if (w_comp_acc && comp_lock) begin
      r_lock_cnt <= (w_cnt_inc >= LOCK_LIM) ? LOCK_LIM : w_cnt_inc;
    end
  end
`else
  // Lock is unbounded; MAX_LOCK only keeps its place in the parameter list.
  assign w_lim_hit = 1'b0;
  assign w_release = (MAX_LOCK < 0);
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= LAST_HOST;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_host_acc) begin
      w_next = LAST_HOST;
    end else if (w_comp_acc) begin
      if (comp_lock && !w_lim_hit) begin
        w_next = LOCKED;
      end else begin
        w_next = LAST_COMP;
      end
    end else if ((r_state == LOCKED) && !comp_valid && !comp_lock) begin
      w_next = LAST_COMP;
    end
  end

  // Round-robin: on contention the requester that did not win last is served.
  always_comb begin
    w_host_ready = 1'b0;
    w_comp_ready = 1'b0;
    if ((r_state == LOCKED) && !w_release) begin
      w_comp_ready = comp_valid;
    end else if (host_valid && comp_valid) begin
      if (r_state == LAST_HOST) begin
        w_comp_ready = 1'b1;
      end else begin
        w_host_ready = 1'b1;
      end
    end else begin
      w_host_ready = host_valid;
      w_comp_ready = comp_valid;
    end
  end

  assign w_host_acc = host_valid && w_host_ready;
  assign w_comp_acc = comp_valid && w_comp_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_host_acc || w_comp_acc;
      if (w_host_acc) begin
        r_mem_we    <= host_we;
        r_mem_addr  <= host_addr;
        r_mem_wdata <= host_wdata;
      end else if (w_comp_acc) begin
        r_mem_we    <= comp_we;
        r_mem_addr  <= comp_addr;
        r_mem_wdata <= comp_wdata;
      end else begin
        r_mem_we <= 1'b0;
      end
    end
  end

  mlaccel_memarb_tagpipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tagpipe (
    .i_clk          (clock),
    .i_rst_n        (resetn),
    .i_push         ((w_host_acc && !host_we) || (w_comp_acc && !comp_we)),
    .i_owner        (w_host_acc ? OWN_HOST : OWN_COMP),
    .o_host_rvalid  (host_rvalid),
    .o_comp_rvalid  (comp_rvalid),
    .o_host_pending (w_host_pending)
  );

  assign host_ready = w_host_ready;
  assign comp_ready = w_comp_ready;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign host_rdata = mem_rdata;
  assign comp_rdata = mem_rdata;
  assign busy       = (host_valid && !w_host_ready) || w_host_pending;

endmodule

// File: tb/tb_mlaccel_memarb.sv
// Directed bench for mlaccel_memarb: behavioural arbiter/memory model plus literal checks.
module tb_mlaccel_memarb;

  localparam int MEM_LAT = 2;
`ifdef MEMARB_LOCK_LIMIT_EN
  localparam int MAX_LOCK = 4;
  localparam bit LIMIT    = 1'b1;
`else
  localparam int MAX_LOCK = 64;
  localparam bit LIMIT    = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        host_valid = 1'b0, host_we = 1'b0;
  logic [15:0] host_addr = '0, host_wdata = '0;
  logic        comp_valid = 1'b0, comp_we = 1'b0, comp_lock = 1'b0;
  logic [15:0] comp_addr = '0, comp_wdata = '0;
  logic        host_ready, host_rvalid, comp_ready, comp_rvalid;
  logic [15:0] host_rdata, comp_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mlaccel_memarb #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .MEM_LAT  (MEM_LAT),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .comp_valid  (comp_valid),
    .comp_ready  (comp_ready),
    .comp_we     (comp_we),
    .comp_addr   (comp_addr),
    .comp_wdata  (comp_wdata),
    .comp_rvalid (comp_rvalid),
    .comp_rdata  (comp_rdata),
    .comp_lock   (comp_lock),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Memory environment: preloaded with data=addr, read data valid MEM_LAT cycles after mem_en.
  logic [15:0] mem [65536];
  logic [15:0] rpipe [MEM_LAT];
  assign mem_rdata = rpipe[MEM_LAT-1];

  initial begin : memenv
    logic        en, we;
    logic [15:0] a, d;
    for (int i = 0; i < 65536; i++) mem[i] = i[15:0];
    for (int i = 0; i < MEM_LAT; i++) rpipe[i] = '0;
    forever begin
      @(negedge clock);
      en = mem_en; we = mem_we; a = mem_addr; d = mem_wdata;
      @(posedge clock);
      for (int i = MEM_LAT - 1; i > 0; i--) rpipe[i] = rpipe[i-1];
      rpipe[0] = 'x;
      if (en && we) mem[a] = d;
      if (en && !we) rpipe[0] = mem[a];
    end
  end

  // Behavioural model: who won last, whether compute holds a lock, and a queue of pending reads.
  typedef struct {
    int          due;
    bit          owner;   // 0 host, 1 compute
    logic [15:0] data;
  } rd_t;

  rd_t         q[$];
  logic [15:0] shadow [65536];
  bit          m_last, m_locked;
  int          m_beats;
  logic        m_en, m_we;
  logic [15:0] m_addr, m_wdata;
  int          cyc = 0;

  initial begin : compare
    bit          eh, ec, hrv, crv, hpend;
    logic [15:0] edata;
    rd_t         r;
    for (int i = 0; i < 65536; i++) shadow[i] = i[15:0];
    forever begin
      @(negedge clock);
      if (!resetn) begin
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
        chk("rst_comp_rvalid", comp_rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_host_ready", host_ready, 0);
        chk("rst_comp_ready", comp_ready, 0);
        q.delete();
        m_last = 0; m_locked = 0; m_beats = 0;
        m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      end else begin
        eh = 0; ec = 0;
        if (m_locked && !(LIMIT && m_beats >= MAX_LOCK && host_valid)) ec = comp_valid;
        else if (host_valid && comp_valid) begin
          if (m_last) eh = 1; else ec = 1;
        end else begin
          eh = host_valid; ec = comp_valid;
        end
        chk("host_ready", host_ready, eh);
        chk("comp_ready", comp_ready, ec);
        chk("mem_en", mem_en, m_en);
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);

        hrv = 0; crv = 0; edata = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          if (q[0].owner) crv = 1; else hrv = 1;
          edata = q[0].data;
        end
        chk("host_rvalid", host_rvalid, hrv);
        chk("comp_rvalid", comp_rvalid, crv);
        if (hrv) chk("host_rdata", host_rdata, edata);
        if (crv) chk("comp_rdata", comp_rdata, edata);
        hpend = 0;
        foreach (q[i]) if (!q[i].owner) hpend = 1;
        chk("busy", busy, (host_valid && !eh) || hpend);
        if (hrv || crv) void'(q.pop_front());

        m_en = 0; m_we = 0;
        if (eh || ec) begin
          m_en   = 1;
          m_we   = eh ? host_we : comp_we;
          m_addr = eh ? host_addr : comp_addr;
          m_wdata = eh ? host_wdata : comp_wdata;
          if (m_we) shadow[m_addr] = m_wdata;
          else begin
            r.due = cyc + MEM_LAT + 1; r.owner = ec; r.data = shadow[m_addr];
            q.push_back(r);
          end
        end
        if (eh) begin
          m_last = 0; m_locked = 0; m_beats = 0;
        end else if (ec) begin
          m_last = 1;
          if (comp_lock) begin
            m_beats++;
            m_locked = !(LIMIT && m_beats >= MAX_LOCK && host_valid);
            if (!m_locked) m_beats = 0;
          end else begin
            m_locked = 0; m_beats = 0;
          end
        end else if (m_locked && !comp_valid && !comp_lock) begin
          m_locked = 0; m_beats = 0;
        end
      end
      cyc++;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [5:0] gseq;
    repeat (3) step();
    chk("reset_mem_en", mem_en, 0);
    chk("reset_busy", busy, 0);
    resetn = 1'b1;
    step();

    // 1: host write then read of 0x0010
    host_valid = 1; host_we = 1; host_addr = 16'h0010; host_wdata = 16'h1234;
    #2 chk("t1_wr_ready", host_ready, 1);
    step();
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_we", mem_we, 1);
    chk("t1_mem_addr", mem_addr, 16'h0010);
    chk("t1_mem_wdata", mem_wdata, 16'h1234);
    host_we = 0;
    #2 chk("t1_rd_ready", host_ready, 1);
    step();
    host_valid = 0;
    for (int i = 0; i < MEM_LAT; i++) begin
      chk("t1_rvalid_early", host_rvalid, 0);
      step();
    end
    chk("t1_rvalid", host_rvalid, 1);
    chk("t1_rdata", host_rdata, 16'h1234);
    chk("t1_comp_rvalid", comp_rvalid, 0);
    step();

    // 2: contention, reads, no lock
    host_valid = 1; host_we = 0; host_addr = 16'h0010;
    comp_valid = 1; comp_we = 0; comp_addr = 16'h0020; comp_lock = 0;
    gseq = '0;
    for (int i = 0; i < 6; i++) begin
      #2 gseq[5-i] = comp_ready;
      step();
    end
    host_valid = 0; comp_valid = 0;
    chk("t2_grants", gseq, 6'b101010);
    repeat (MEM_LAT + 2) step();

`ifndef MEMARB_LOCK_LIMIT_EN
    // 3: locked compute burst holds off a waiting host
    host_valid = 1; host_we = 0; host_addr = 16'h0030;
    comp_valid = 1; comp_we = 1; comp_lock = 1;
    for (int i = 0; i < 4; i++) begin
      comp_addr = 16'h0400 + 16'(i); comp_wdata = 16'hA000 + 16'(i);
      #2 chk("t3_host_ready", host_ready, 0);
      chk("t3_comp_ready", comp_ready, 1);
      chk("t3_busy", busy, 1);
      step();
    end
    comp_lock = 0; comp_addr = 16'h0404; comp_wdata = 16'hA004;
    #2 chk("t3_unlock_host", host_ready, 0);
    chk("t3_unlock_comp", comp_ready, 1);
    chk("t3_unlock_busy", busy, 1);
    step();
    comp_valid = 0;
    #2 chk("t3_host_granted", host_ready, 1);
    step();
    host_valid = 0;
    repeat (MEM_LAT + 2) step();
`else
    // 5: lock limit releases the host after MAX_LOCK compute beats
    begin
      int ncomp, at;
      ncomp = 0; at = -1;
      host_valid = 1; host_we = 0; host_addr = 16'h0030;
      comp_valid = 1; comp_we = 1; comp_lock = 1;
      for (int i = 0; i < 12 && at < 0; i++) begin
        comp_addr = 16'h0500 + 16'(ncomp); comp_wdata = 16'hB000 + 16'(ncomp);
        #2 if (host_ready) at = ncomp; else if (comp_ready) ncomp++;
        step();
      end
      host_valid = 0; comp_valid = 0; comp_lock = 0;
      chk("t5_host_after", at, 4);
      repeat (MEM_LAT + 2) step();
    end
`endif

    // 4: reset during two outstanding host reads
    host_valid = 1; host_we = 0; host_addr = 16'h0010;
    step();
    host_addr = 16'h0011;
    step();
    host_valid = 0;
    #2 chk("t4_busy_before", busy, 1);
    resetn = 0;
    #1 chk("t4_mem_en", mem_en, 0);
    chk("t4_mem_addr", mem_addr, 0);
    chk("t4_host_rvalid", host_rvalid, 0);
    chk("t4_busy", busy, 0);
    step();
    step();
    resetn = 1;
    for (int i = 0; i < MEM_LAT + 3; i++) begin
      #2 chk("t4_no_rvalid", host_rvalid, 0);
      chk("t4_no_busy", busy, 0);
      step();
    end

    // 6: host download of 64 words, data == addr
    host_valid = 1; host_we = 1; host_addr = 16'h0010; host_wdata = 16'h0010;
    step();
    host_valid = 0;
    step();
    fork
      begin
        host_valid = 1; host_we = 0;
        for (int i = 0; i < 64; i++) begin
          host_addr = 16'(i);
          step();
        end
        host_valid = 0;
        for (int i = 0; i <= MEM_LAT; i++) begin
          #2 chk("t6_busy_tail", busy, 1);
          step();
        end
        #2 chk("t6_busy_clear", busy, 0);
      end
      begin
        int n;
        n = 0;
        for (int c = 0; c < 64 + MEM_LAT + 8; c++) begin
          @(negedge clock);
          if (host_rvalid) begin
            chk("t6_rdata", host_rdata, n);
            n++;
          end
        end
        chk("t6_count", n, 64);
      end
    join

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
